// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: groups the keypad matrix lines and the decoded-key outputs.
//   col_n     : column returns, active-low (driven by the keypad side)
//   row_n     : row drive, active-low one-hot (driven by the scanner)
//   key_valid : one-cycle pulse on an accepted press
//   key_code  : hex code of the last accepted key
//   key_down  : high while the accepted key is held
// Modports: master = scanner side, slave = keypad/consumer side.
interface keypad_scanner_if;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_down;

    modport master (input col_n, output row_n, output key_valid, output key_code, output key_down);
    modport slave  (output col_n, input row_n, input key_valid, input key_code, input key_down);
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 hex keypad with active-low rows, debounces
// presses and releases on scan ticks, and reports one code per press.
//   clk   : system clock
//   reset : synchronous, active-high reset
//   kp    : keypad_scanner_if.master (col_n in; row_n, key_valid, key_code,
//           key_down out)
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,  // cycles per row dwell, >= 4
    parameter int DEBOUNCE_TICKS = 4      // 1..15
) (
    input  logic               clk,
    input  logic               reset,
    keypad_scanner_if.master   kp
);
    localparam int DIV_W = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    state_t           state_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       col_meta_q, col_s_q, col_lat_q;
    logic [3:0]       row_n_q;
    logic [3:0]       deb_cnt_q, rel_cnt_q;
    logic [3:0]       deb_inc_d, rel_inc_d;
    logic             key_valid_q, key_down_q;
    logic [3:0]       key_code_q;
    logic             tick, hit;
    logic [3:0]       col_low;

    function automatic logic [1:0] one_cold_idx(input logic [3:0] v);
        case (v)
            4'b1110: return 2'd0;
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: return 4'h1;  4'h1: return 4'h2;  4'h2: return 4'h3;  4'h3: return 4'hA;
            4'h4: return 4'h4;  4'h5: return 4'h5;  4'h6: return 4'h6;  4'h7: return 4'hB;
            4'h8: return 4'h7;  4'h9: return 4'h8;  4'hA: return 4'h9;  4'hB: return 4'hC;
            4'hC: return 4'h0;  4'hD: return 4'hF;  4'hE: return 4'hE;  default: return 4'hD;
        endcase
    endfunction

    // Columns are sampled only in the last cycle of a dwell so the row
    // change has had the whole dwell (minus synchronizer delay) to settle.
    assign tick  = (div_q == DIV_W'(SCAN_DIV - 1));
    assign div_d = tick ? '0 : div_q + 1'b1;

    // Exactly one low column is a hit; none or several (ghosting) is not.
    assign col_low = ~col_s_q;
    assign hit     = (col_low != 4'h0) && ((col_low & (col_low - 4'h1)) == 4'h0);

    assign deb_inc_d = deb_cnt_q + 4'd1;
    assign rel_inc_d = rel_cnt_q + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SCAN;
            div_q       <= '0;
            col_meta_q  <= 4'hF;
            col_s_q     <= 4'hF;
            col_lat_q   <= 4'hF;
            row_n_q     <= 4'b1110;
            deb_cnt_q   <= 4'd0;
            rel_cnt_q   <= 4'd0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            key_down_q  <= 1'b0;
        end else begin
            col_meta_q  <= kp.col_n;
            col_s_q     <= col_meta_q;
            div_q       <= div_d;
            key_valid_q <= 1'b0;
            if (tick) begin
                case (state_q)
                    SCAN: begin
                        if (hit) begin
                            col_lat_q <= col_s_q;
                            if (DEBOUNCE_TICKS == 1) begin
                                key_valid_q <= 1'b1;
                                key_code_q  <= key_map(one_cold_idx(row_n_q), one_cold_idx(col_s_q));
                                key_down_q  <= 1'b1;
                                deb_cnt_q   <= 4'd0;
                                rel_cnt_q   <= 4'd0;
                                state_q     <= HELD;
                            end else begin
                                deb_cnt_q <= 4'd1;
                                state_q   <= DEBOUNCE;
                            end
                        end else begin
                            row_n_q <= {row_n_q[2:0], row_n_q[3]};
                        end
                    end
                    DEBOUNCE: begin
                        // col_lat_q holds a single low bit, so equality means
                        // the same lone column is still the only one pressed.
                        if (col_s_q == col_lat_q) begin
                            if (deb_inc_d == 4'(DEBOUNCE_TICKS)) begin
                                key_valid_q <= 1'b1;
                                key_code_q  <= key_map(one_cold_idx(row_n_q), one_cold_idx(col_lat_q));
                                key_down_q  <= 1'b1;
                                deb_cnt_q   <= 4'd0;
                                rel_cnt_q   <= 4'd0;
                                state_q     <= HELD;
                            end else begin
                                deb_cnt_q <= deb_inc_d;
                            end
                        end else begin
                            // Row is kept; the advance happens on the next tick.
                            deb_cnt_q <= 4'd0;
                            state_q   <= SCAN;
                        end
                    end
                    HELD: begin
                        if (col_s_q == 4'hF) begin
                            if (rel_inc_d == 4'(DEBOUNCE_TICKS)) begin
                                rel_cnt_q  <= 4'd0;
                                key_down_q <= 1'b0;
                                row_n_q    <= {row_n_q[2:0], row_n_q[3]};
                                state_q    <= SCAN;
                            end else begin
                                rel_cnt_q <= rel_inc_d;
                            end
                        end else begin
                            rel_cnt_q <= 4'd0;
                        end
                    end
                    default: state_q <= SCAN;
                endcase
            end
        end
    end

    assign kp.row_n     = row_n_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_down  = key_down_q;
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Scans a 4x4 hex keypad matrix and reports debounced key presses as 4-bit hex codes. It is the input-side counterpart of the multiplexed seven-segment display driver. It time-multiplexes active-low row drives the same way the display driver time-multiplexes anodes, reads the active-low column returns, and emits one code per press. Output feeds the hex digit registers that drive the display.

Parameters:
SCAN_DIV, 1000, clock cycles per row dwell; legal minimum 4
DEBOUNCE_TICKS, 4, consecutive matching scan ticks required to accept a press or a release; legal range 1..15

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
col_n  input  4  column returns, active-low, externally pulled up, asynchronous to clk
row_n  output  4  row drive, active-low one-hot
key_valid  output  1  one-cycle pulse when a debounced press is accepted
key_code  output  4  hex code of last accepted key; held until next accept
key_down  output  1  high while the accepted key is held

Behaviour:
- Reset is synchronous and active-high, single clock clk. On reset: row_n=4'b1110 (row 0); key_valid=0; key_code=4'h0; key_down=0; FSM=SCAN; all counters=0.
- col_n passes through a 2-flop synchronizer to col_s. All decisions use col_s.
- Divider counts 0..SCAN_DIV-1 and wraps. A tick is asserted in the cycle the divider equals SCAN_DIV-1. Columns are sampled only on tick, i.e. the last cycle of a row dwell, which allows settling.
- Valid hit: exactly one bit of col_s is low. Zero or two or more low bits (ghosting or multi-press) count as no hit.
- FSM states:
  - SCAN: on tick with no hit, advance the row (0->1->2->3->0) by rotating row_n left. On tick with a valid hit, latch row and col, keep the row, set deb_cnt=1, go to DEBOUNCE. If DEBOUNCE_TICKS=1, go straight to accept instead.
  - DEBOUNCE: row frozen. On tick:
    - same single column low: deb_cnt++. When deb_cnt reaches DEBOUNCE_TICKS, accept: key_valid=1 for exactly that cycle, key_code=map(row,col), key_down=1, go to HELD.
    - anything else: deb_cnt=0, go to SCAN without advancing the row (the advance happens on the next tick).
  - HELD: row frozen, key_down=1. On tick:
    - all columns high: rel_cnt++.
    - otherwise: rel_cnt=0.
    - When rel_cnt reaches DEBOUNCE_TICKS: key_down=0, advance the row, go to SCAN.
- A held key never produces repeat pulses. A second key pressed while in HELD is ignored, and the first key's release is not seen while the second key is down.
- Key map (row,col -> code):
  - row0: 1,2,3,A
  - row1: 4,5,6,B
  - row2: 7,8,9,C
  - row3: 0,F,E,D
  - col0 is the leftmost column.
- Latency: the first valid-hit tick to key_valid is DEBOUNCE_TICKS-1 further ticks, with key_valid registered in the cycle after that tick. The synchronizer adds 2 cycles before a col_n change is visible.
- key_code changes only on accept. key_valid is never asserted outside DEBOUNCE->HELD.
- Reset mid-operation (any state) returns everything to reset values on the next edge. No pulse is generated, and a still-pressed key is re-detected from SCAN.
- Counter widths: divider ceil(log2(SCAN_DIV)); deb_cnt and rel_cnt 4 bits each. No overflow is possible given the legal ranges.

Test Plan:
All scenarios use SCAN_DIV=8 and DEBOUNCE_TICKS=3.
1. Reset, then no key pressed for 64 cycles -> row_n cycles 1110,1101,1011,0111,1110 with 8 cycles per row; key_valid stays 0; key_code=0; key_down=0.
2. Hold col_n=4'b1101 whenever row_n=4'b1011 (row2,col1) -> exactly one key_valid pulse with key_code=4'h8. key_down=1 and row_n frozen at 1011 while held. After release, key_down=0 after 3 ticks and the row advances to 0111.
3. Bounce: col1 on row1 low for 1 tick, high for 1 tick, then low steadily -> no pulse on the first contact; then one pulse with key_code=4'h5.
4. Ghosting: col_n=4'b1100 on row0 -> no key_valid and scanning continues. Then a single press at row3,col3 -> key_code=4'hD.
5. Long hold for 50 ticks on row3,col0 -> exactly one pulse with key_code=4'h0. A second key (row3,col2) pressed during the hold produces no pulse.
6. Assert reset for 1 cycle while in HELD with key 'A' held -> key_down=0, row_n=1110, key_code=0. The key is re-detected with one new pulse and key_code=4'hA.
